ifetch_buffer: RTL and testbench
================================

// Module: ifetch_buffer
// PURPOSE
//   Instruction-fetch front end placed directly upstream of the core. Generates sequential IMEM
//   read requests, absorbs variable IMEM latency in a small in-order FIFO, and hands the core
//   {instr, pc} with a valid/ready handshake. Redirects from the core (branch/jump) flush
//   buffered and in-flight instructions and restart fetch at the new PC.
// PARAMETERS
//   DEPTH        4             instruction FIFO entries (power of 2, >=2)
//   MAX_OUTST    2             max IMEM requests in flight (1..DEPTH)
//   RESET_PC     32'h00000000  first fetch address after reset
// PORTS
//   clk             in   1   clock, all state on rising edge
//   rst_n           in   1   asynchronous, active-low reset
//   redirect_valid  in   1   core requests fetch restart
//   redirect_pc     in   32  restart address (word aligned)
//   imem_req_valid  out  1   IMEM read request valid
//   imem_req_ready  in   1   IMEM accepts request
//   imem_req_addr   out  32  request address
//   imem_resp_valid in   1   IMEM read data valid (in order, >=1 cycle after accept)
//   imem_resp_data  in   32  IMEM read data
//   instr_valid     out  1   FIFO head valid to core
//   instr_ready     in   1   core consumes head
//   instr           out  32  head instruction (NOP 32'h00000013 when !instr_valid)
//   instr_pc        out  32  PC of head instruction
// BEHAVIOUR
//   Reset: imem_req_valid=0, imem_req_addr=RESET_PC, instr_valid=0, instr=NOP, instr_pc=0,
//     fetch_pc=RESET_PC, outstanding=0, stale=0, FIFO empty, state=RUN. First request cycle 1 after release.
//   Request issue (RUN only): imem_req_valid=1 iff outstanding<MAX_OUTST and
//     occupancy+outstanding<DEPTH (credit rule; FIFO never overflows, resp never back-pressured).
//     Accept = valid&ready -> fetch_pc+=4, outstanding+=1. Valid/addr held stable until accepted
//     unless a redirect occurs (redirect may withdraw a pending request).
//   Response: outstanding-=1; if stale>0 then stale-=1 and data dropped, else push {data, pc}.
//     PC of pushed entry tracked by resp_pc register (+=4 per push, loaded on redirect).
//     Simultaneous accept and response: outstanding unchanged.
//   Pop: instr_valid&instr_ready removes head; zero-latency output from head registers.
//     Push and pop same cycle on full FIFO legal (credit rule keeps it consistent).
//   Redirect (highest priority): FIFO cleared, pop ignored, stale<=outstanding (including a
//     response arriving this same cycle, counted stale), fetch_pc/resp_pc<=redirect_pc.
//     If stale result==0 -> stay RUN, request next cycle; else -> FLUSH.
//   FSM: RUN --redirect & in-flight>0--> FLUSH; FLUSH --stale reaches 0--> RUN (request same
//     cycle stale hits 0 is not issued; first new request next cycle). Redirect in FLUSH reloads
//     PCs, stale tracks current outstanding.
//   Widths: outstanding/stale $clog2(MAX_OUTST+1) bits, occupancy $clog2(DEPTH+1); PCs wrap mod 2^32.
//   instr_valid drops cycle after redirect; no stale instruction ever reaches the core.
// CONFIGURATION
//   IFETCH_PERF_EN defined: adds outputs perf_fetched[31:0] (pushed instrs), perf_flushed[31:0]
//     (FIFO entries + stale responses discarded), perf_stall[31:0] (cycles instr_ready&!instr_valid);
//     all reset to 0, wrap at 2^32. Undefined: ports and counters absent, behaviour otherwise identical.
// STRUCTURE
//   Shared riscv_defs package: XLEN, NOP_INSTR=32'h00000013, RESET_PC default, FSM state encodings.
//   One sub-module: sync_fifo (width 64 {pc,instr}, DEPTH, flush input, count output).
//   Credit/stale counters, PC registers and FSM in ifetch_buffer top.
// TESTING
//   1 Reset, ready=1, IMEM 1-cycle latency, instr_ready=1 -> addrs 0,4,8..., instr_pc matches, 1 instr/cycle after fill.
//   2 instr_ready=0 -> exactly DEPTH=4 requests accepted, then imem_req_valid=0; resume on ready.
//   3 imem_req_ready low 3 cycles -> addr/valid held stable, no duplicate or skipped PC.
//   4 Redirect to 0x100 with 2 in flight, 3-cycle latency -> FLUSH, 2 responses dropped, next instr_pc=0x100.
//   5 Redirect same cycle as response and pop -> response dropped, pop ignored, instr_valid=0 next cycle.
//   6 Reset asserted mid-FLUSH -> all outputs at reset values immediately; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/riscv_defs_pkg.sv
// Shared RISC-V front-end definitions: data widths, the canonical NOP, the default boot PC,
// the fetch FSM states and the {pc, instr} FIFO entry layout.
package riscv_defs_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// In-order synchronous FIFO with a single-cycle flush and an occupancy count.
// The head entry is presented combinationally from the storage registers.
module sync_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_data_c,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_data_c = mem_q[rd_ptr_q];
    assign count       = count_q;

endmodule

// File: rtl/ifetch_buffer.sv
// Instruction-fetch front end: credit-limited sequential IMEM requests, in-order buffering,
// redirect flush with stale-response dropping. Optional counters under IFETCH_PERF_EN.
module ifetch_buffer
    import riscv_defs_pkg::*;
#(
    parameter int unsigned     DEPTH     = 4,
    parameter int unsigned     MAX_OUTST = 2,
    parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc
`ifdef IFETCH_PERF_EN
    ,
    output logic [31:0]     perf_fetched,
    output logic [31:0]     perf_flushed,
    output logic [31:0]     perf_stall
`endif
);

    localparam int unsigned OUT_W = $clog2(MAX_OUTST + 1);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned SUM_W = $clog2(2 * DEPTH + 1);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] resp_pc_q, resp_pc_d;
    logic [OUT_W-1:0] outstanding_q, outstanding_d;
    logic [OUT_W-1:0] stale_q, stale_d;
    logic            req_valid_q, req_valid_d;
    logic [XLEN-1:0] req_addr_q, req_addr_d;

    logic            accept;
    logic            push;
    logic            pop;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W-1:0] occ_next;
    fetch_entry_t    push_entry;
    fetch_entry_t    head_entry;

    assign accept     = req_valid_q & imem_req_ready;
    assign push       = imem_resp_valid & (stale_q == '0) & ~redirect_valid;
    assign pop        = instr_valid & instr_ready & ~redirect_valid;
    assign push_entry = '{pc: resp_pc_q, instr: imem_resp_data};

    sync_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (redirect_valid),
        .push        (push),
        .push_data   (push_entry),
        .pop         (pop),
        .head_data_c (head_entry),
        .count       (fifo_count)
    );

    // Fetch FSM, credit/stale accounting and the registered request for next cycle
    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        stale_d       = stale_q;
        outstanding_d = outstanding_q + OUT_W'(accept) - OUT_W'(imem_resp_valid);
        occ_next      = fifo_count + CNT_W'(push) - CNT_W'(pop);

        if (accept) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end
        if (push) begin
            resp_pc_d = resp_pc_q + 32'd4;
        end
        if (imem_resp_valid && (stale_q != '0)) begin
            stale_d = stale_q - OUT_W'(1);
        end

        if (redirect_valid) begin
            // Everything still in flight after this edge, incl. a same-cycle accept, is stale
            fetch_pc_d = redirect_pc;
            resp_pc_d  = redirect_pc;
            stale_d    = outstanding_d;
            occ_next   = '0;
            state_d    = (outstanding_d == '0) ? ST_RUN : ST_FLUSH;
        end else begin
            case (state_q)
                ST_RUN:   state_d = ST_RUN;
                ST_FLUSH: if (stale_d == '0) state_d = ST_RUN;
                default:  state_d = ST_RUN;
            endcase
        end

        req_valid_d = (state_d == ST_RUN)
                   && (outstanding_d < OUT_W'(MAX_OUTST))
                   && ((SUM_W'(occ_next) + SUM_W'(outstanding_d)) < SUM_W'(DEPTH));
        req_addr_d  = fetch_pc_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_RUN;
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            stale_q       <= '0;
            req_valid_q   <= 1'b0;
            req_addr_q    <= RESET_PC;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            stale_q       <= stale_d;
            req_valid_q   <= req_valid_d;
            req_addr_q    <= req_addr_d;
        end
    end

    assign imem_req_valid = req_valid_q;
    assign imem_req_addr  = req_addr_q;
    assign instr_valid    = (fifo_count != '0);
    assign instr          = instr_valid ? head_entry.instr : NOP_INSTR;
    assign instr_pc       = instr_valid ? head_entry.pc : '0;

`ifdef IFETCH_PERF_EN
    logic [31:0] perf_fetched_q, perf_fetched_d;
    logic [31:0] perf_flushed_q, perf_flushed_d;
    logic [31:0] perf_stall_q, perf_stall_d;
    logic        resp_drop;

    assign resp_drop = imem_resp_valid & ((stale_q != '0) | redirect_valid);

    always_comb begin
        perf_fetched_d = perf_fetched_q + 32'(push);
        perf_flushed_d = perf_flushed_q + 32'(resp_drop)
                       + (redirect_valid ? 32'(fifo_count) : 32'd0);
        perf_stall_d   = perf_stall_q + 32'(instr_ready & ~instr_valid);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched_q <= '0;
            perf_flushed_q <= '0;
            perf_stall_q   <= '0;
        end else begin
            perf_fetched_q <= perf_fetched_d;
            perf_flushed_q <= perf_flushed_d;
            perf_stall_q   <= perf_stall_d;
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_flushed = perf_flushed_q;
    assign perf_stall   = perf_stall_q;
`endif

endmodule

// File: tb/tb_ifetch_buffer.sv
// Self-checking bench for ifetch_buffer: IMEM latency model plus an expected-instruction scoreboard.
`timescale 1ns/1ps
module tb_ifetch_buffer;

    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [31:0] BOOT_PC  = 32'h0000_0000;
    localparam int          DEPTH_TB = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
`ifdef IFETCH_PERF_EN
    logic [31:0] perf_fetched, perf_flushed, perf_stall;
`endif

    ifetch_buffer dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .instr           (instr),
        .instr_pc        (instr_pc)
`ifdef IFETCH_PERF_EN
        ,
        .perf_fetched    (perf_fetched),
        .perf_flushed    (perf_flushed),
        .perf_stall      (perf_stall)
`endif
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; int due; } imem_t;
    typedef struct { logic [31:0] pc; logic [31:0] ins; } exp_t;

    imem_t       imem_q[$];
    exp_t        sb_q[$];
    int          compared = 0;
    int          mismatched = 0;
    int          cyc = 0;
    int          lat = 1;
    int          imem_stall = 0;
    bit          core_ready = 1'b0;
    bit          redir_pend = 1'b0;
    bit          redir_sync = 1'b0;
    logic [31:0] redir_target = '0;
    int          redir_done = 0;
    int          pop_cnt = 0;
    logic [31:0] last_pop_pc = '0;
    logic [31:0] exp_pc = BOOT_PC;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    // IMEM + core environment; drives all inputs at negedge and scoreboards every pop
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            imem_q.delete();
            sb_q.delete();
            imem_resp_valid = 1'b0;
            imem_resp_data  = '0;
            imem_req_ready  = 1'b0;
            redirect_valid  = 1'b0;
            instr_ready     = 1'b0;
            redir_pend      = 1'b0;
            exp_pc          = BOOT_PC;
        end else begin
            imem_resp_valid = 1'b0;
            if (imem_q.size() > 0 && imem_q[0].due <= cyc) begin
                imem_resp_valid = 1'b1;
                imem_resp_data  = mem_data(imem_q[0].addr);
                void'(imem_q.pop_front());
            end
            imem_req_ready = (imem_stall == 0);
            if (imem_stall > 0) imem_stall--;
            instr_ready    = core_ready;
            redirect_valid = redir_pend &&
                (!redir_sync || (imem_resp_valid && instr_valid && core_ready));
            redirect_pc    = redir_target;

            if (imem_req_valid && imem_req_ready) begin
                compared++;
                if (imem_req_addr !== exp_pc) begin
                    mismatched++;
                    $display("FAIL req_addr: got %h expected %h (cycle %0d)", imem_req_addr, exp_pc, cyc);
                end
                imem_q.push_back('{addr: imem_req_addr, due: cyc + lat});
                if (!redirect_valid) sb_q.push_back('{pc: exp_pc, ins: mem_data(exp_pc)});
                exp_pc += 32'd4;
            end

            if (instr_valid && instr_ready && !redirect_valid) begin
                pop_cnt++;
                last_pop_pc = instr_pc;
                compared++;
                if (sb_q.size() == 0) begin
                    mismatched++;
                    $display("FAIL pop_unexpected: got pc %h instr %h with nothing expected", instr_pc, instr);
                end else begin
                    e = sb_q.pop_front();
                    if (instr_pc !== e.pc || instr !== e.ins) begin
                        mismatched++;
                        $display("FAIL pop_data: got pc %h instr %h expected pc %h instr %h",
                                 instr_pc, instr, e.pc, e.ins);
                    end
                end
            end else if (!instr_valid) begin
                compared++;
                if (instr !== NOP) begin
                    mismatched++;
                    $display("FAIL idle_nop: got %h expected %h", instr, NOP);
                end
            end

            if (redirect_valid) begin
                sb_q.delete();
                exp_pc     = redir_target;
                redir_pend = 1'b0;
                redir_done++;
            end
        end
        cyc++;
    end

    task automatic wait_imem_two();
        int n = 0;
        while (imem_q.size() != 2 && n < 40) begin @(negedge clk); #1; n++; end
        compared++;
        if (imem_q.size() != 2) begin
            mismatched++;
            $display("FAIL inflight_two: got %0d in flight expected 2", imem_q.size());
        end
    endtask

    task automatic do_redirect(input logic [31:0] tgt, input bit sync);
        int d0 = redir_done;
        int n = 0;
        redir_target = tgt;
        redir_sync   = sync;
        redir_pend   = 1'b1;
        while (redir_done == d0 && n < 60) begin @(negedge clk); #1; n++; end
        compared++;
        if (redir_done == d0) begin
            mismatched++;
            $display("FAIL redirect_issue: got no redirect expected one to %h", tgt);
            redir_pend = 1'b0;
        end
    endtask

    task automatic expect_next_pop_pc(input logic [31:0] want);
        int p0 = pop_cnt;
        int n = 0;
        while (pop_cnt == p0 && n < 60) begin @(negedge clk); #1; n++; end
        compared++;
        if (pop_cnt == p0 || last_pop_pc !== want) begin
            mismatched++;
            $display("FAIL first_pop_pc: got %h (pops %0d) expected %h", last_pop_pc, pop_cnt - p0, want);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        compared++;
        if (imem_req_valid !== 1'b0 || imem_req_addr !== BOOT_PC || instr_valid !== 1'b0 ||
            instr !== NOP || instr_pc !== 32'h0) begin
            mismatched++;
            $display("FAIL %s: got v=%b a=%h iv=%b i=%h pc=%h expected 0 %h 0 %h 0",
                     tag, imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc, BOOT_PC, NOP);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; core_ready = 1'b0; lat = 1; imem_stall = 0;
        redirect_valid = 1'b0; redirect_pc = '0; imem_req_ready = 1'b0;
        imem_resp_valid = 1'b0; imem_resp_data = '0; instr_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs("reset_values");
        rst_n = 1'b1;
        @(negedge clk); #1;
        compared++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== BOOT_PC) begin
            mismatched++;
            $display("FAIL first_request: got v=%b a=%h expected 1 %h", imem_req_valid, imem_req_addr, BOOT_PC);
        end
    endtask

    task automatic test_stream();
        int p0;
        core_ready = 1'b1;
        repeat (8) @(negedge clk);
        #1;
        p0 = pop_cnt;
        repeat (10) @(negedge clk);
        #1;
        compared++;
        if (pop_cnt - p0 != 10) begin
            mismatched++;
            $display("FAIL stream_rate: got %0d pops expected 10", pop_cnt - p0);
        end
    endtask

    task automatic test_backpressure();
        int p0;
        core_ready = 1'b0;
        repeat (12) @(negedge clk);
        #1;
        compared++;
        if (sb_q.size() != DEPTH_TB || imem_req_valid !== 1'b0 || instr_valid !== 1'b1) begin
            mismatched++;
            $display("FAIL full_stop: got buffered=%0d req_valid=%b instr_valid=%b expected %0d 0 1",
                     sb_q.size(), imem_req_valid, instr_valid, DEPTH_TB);
        end
        core_ready = 1'b1;
        p0 = pop_cnt;
        repeat (6) @(negedge clk);
        #1;
        compared++;
        if (pop_cnt - p0 != 6) begin
            mismatched++;
            $display("FAIL resume_rate: got %0d pops expected 6", pop_cnt - p0);
        end
    endtask

    task automatic test_req_stall();
        logic [31:0] a0;
        imem_stall = 3;
        @(negedge clk); #1;
        a0 = imem_req_addr;
        compared++;
        if (imem_req_valid !== 1'b1) begin
            mismatched++;
            $display("FAIL stall_valid: got %b expected 1", imem_req_valid);
        end
        repeat (3) begin
            @(negedge clk); #1;
            compared++;
            if (imem_req_valid !== 1'b1 || imem_req_addr !== a0) begin
                mismatched++;
                $display("FAIL stall_hold: got v=%b a=%h expected 1 %h", imem_req_valid, imem_req_addr, a0);
            end
        end
        repeat (10) @(negedge clk);
        #1;
    endtask

    task automatic test_redirect_flush();
        lat = 3;
        repeat (10) @(negedge clk);
        #1;
        wait_imem_two();
        do_redirect(32'h0000_0100, 1'b0);
        @(negedge clk); #1;
        compared++;
        if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL flush_quiet: got req_valid=%b instr_valid=%b expected 0 0", imem_req_valid, instr_valid);
        end
        expect_next_pop_pc(32'h0000_0100);
        repeat (10) @(negedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        lat = 1;
        repeat (8) @(negedge clk);
        #1;
        do_redirect(32'h0000_0200, 1'b1);
        @(negedge clk); #1;
        compared++;
        if (instr_valid !== 1'b0 || instr !== NOP) begin
            mismatched++;
            $display("FAIL collide_drop: got instr_valid=%b instr=%h expected 0 %h", instr_valid, instr, NOP);
        end
        expect_next_pop_pc(32'h0000_0200);
        repeat (8) @(negedge clk);
        #1;
    endtask

    task automatic test_reset_mid_flush();
        lat = 3;
        repeat (8) @(negedge clk);
        #1;
        wait_imem_two();
        do_redirect(32'h0000_0300, 1'b0);
        @(negedge clk); #1;
        compared++;
        if (imem_req_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL in_flush: got req_valid=%b expected 0", imem_req_valid);
        end
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("async_reset");
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk); #1;
        compared++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== BOOT_PC) begin
            mismatched++;
            $display("FAIL restart_request: got v=%b a=%h expected 1 %h", imem_req_valid, imem_req_addr, BOOT_PC);
        end
        expect_next_pop_pc(BOOT_PC);
        repeat (12) @(negedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_req_stall();
        test_redirect_flush();
        test_back_to_back();
        test_reset_mid_flush();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
